// File: rtl/mux4x1_str.sv
// rtl/mux4x1_str.sv - structural 4:1 mux with combinational out and registered out_q
//
// Purpose:
//   Gate-level 4-to-1 multiplexer, replicated per bit, plus a registered copy of the result
//   for consumers that need a flop boundary.
// Ports:
//   out    WIDTH  combinational result: {s1,s2}=00->i0, 01->i1, 10->i2, 11->i3
//   i0..i3 WIDTH  data inputs
//   s1     1      select MSB
//   s2     1      select LSB
//   clk    1      rising-edge clock, used only by out_q
//   rst_n  1      asynchronous active-low reset, clears only out_q
//   out_q  WIDTH  out registered on clk (1-cycle latency)
module mux4x1_str #(
  parameter int WIDTH = 1
) (
  output wire  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0]       i0,
  input  logic [WIDTH-1:0]       i1,
  input  logic [WIDTH-1:0]       i2,
  input  logic [WIDTH-1:0]       i3,
  input  logic                   s1,
  input  logic                   s2,
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [WIDTH-1:0]       out_q
);

  // Inverted selects are shared by every bit slice.
  wire s1n;
  wire s2n;

  not u_inv_s1 (s1n, s1);
  not u_inv_s2 (s2n, s2);

  // Sum-of-products per bit: exactly one AND term is enabled by the selects, so an
  // unselected data input is gated off and cannot disturb its bit of out.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    wire t0;
    wire t1;
    wire t2;
    wire t3;

    and u_and0 (t0, i0[g], s1n, s2n);
    and u_and1 (t1, i1[g], s1n, s2 );
    and u_and2 (t2, i2[g], s1 , s2n);
    and u_and3 (t3, i3[g], s1 , s2 );
    or  u_or   (out[g], t0, t1, t2, t3);
  end

  // Registered copy; reset only touches this flop, never the combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux4x1_str.sv
// tb/tb_mux4x1_str.sv - randomized self-checking bench for mux4x1_str
module tb_mux4x1_str;

  logic       clk;
  logic       rst_n;
  logic [1:0] sel;
  logic [0:0] d1 [4];
  logic [7:0] d8 [4];
  wire        s1 = sel[1];
  wire        s2 = sel[0];

  wire  [0:0] out1;
  wire  [0:0] out1_q;
  wire  [7:0] out8;
  wire  [7:0] out8_q;

  int total;
  int bad;

  mux4x1_str #(.WIDTH(1)) u_dut1 (
    .out   (out1),
    .i0    (d1[0]),
    .i1    (d1[1]),
    .i2    (d1[2]),
    .i3    (d1[3]),
    .s1    (s1),
    .s2    (s2),
    .clk   (clk),
    .rst_n (rst_n),
    .out_q (out1_q)
  );

  mux4x1_str #(.WIDTH(8)) u_dut8 (
    .out   (out8),
    .i0    (d8[0]),
    .i1    (d8[1]),
    .i2    (d8[2]),
    .i3    (d8[3]),
    .s1    (s1),
    .s2    (s2),
    .clk   (clk),
    .rst_n (rst_n),
    .out_q (out8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the selected input is simply the array entry indexed by {s1,s2}.
  function automatic logic [7:0] ref8(input logic [1:0] s);
    return d8[s];
  endfunction

  function automatic logic ref1(input logic [1:0] s);
    return d1[s][0];
  endfunction

  task automatic set_all(input logic [7:0] v8, input logic v1);
    for (int k = 0; k < 4; k++) begin
      d8[k] = v8;
      d1[k] = v1;
    end
  endtask

  logic [7:0] exp_q8;
  logic       exp_q1;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sel   = 2'b00;
    set_all(8'h00, 1'b0);

    // Reset state and all-zero inputs
    #2;
    chk("reset_q1", {7'd0, out1_q}, 8'h00);
    chk("reset_q8", out8_q, 8'h00);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("zeros_out1", {7'd0, out1}, 8'h00);
      chk("zeros_out8", out8, 8'h00);
    end

    // All ones on every input: all-ones out for every select
    set_all(8'hff, 1'b1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("ones_out1", {7'd0, out1}, 8'h01);
      chk("ones_out8", out8, 8'hff);
    end

    // Pattern 1010 on i0..i3
    d1[0] = 1'b1; d1[1] = 1'b0; d1[2] = 1'b1; d1[3] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("pat1010", {7'd0, out1}, (s % 2 == 0) ? 8'h01 : 8'h00);
    end

    // Exhaustive 64-combination sweep on the 1-bit instance, random data on the 8-bit one
    for (int v = 0; v < 64; v++) begin
      for (int k = 0; k < 4; k++) d1[k] = 1'((v >> k) & 1);
      for (int k = 0; k < 4; k++) d8[k] = 8'($urandom);
      sel = 2'(v >> 4);
      #1;
      chk("exh_out1", {7'd0, out1}, {7'd0, ref1(sel)});
      chk("exh_out8", out8, ref8(sel));
    end

    // One-hot data: out is 1 only when the hot input is selected
    for (int hot = 0; hot < 4; hot++) begin
      for (int k = 0; k < 4; k++) d1[k] = (k == hot);
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        chk("onehot", {7'd0, out1}, (s == hot) ? 8'h01 : 8'h00);
      end
    end

    // Select change with data steady switches out in the same time step
    d8[0] = 8'h3c; d8[1] = 8'hc3; d8[2] = 8'h5a; d8[3] = 8'ha5;
    sel = 2'b00;
    #1;
    sel = 2'b11;
    #0;
    #0;
    chk("sel_switch", out8, 8'ha5);

    // Held in reset with clk toggling: out_q stays 0 though out is 1
    set_all(8'h00, 1'b0);
    d1[1] = 1'b1;
    d8[1] = 8'h22;
    sel   = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_out1", {7'd0, out1}, 8'h01);
      chk("rst_hold_q1", {7'd0, out1_q}, 8'h00);
      chk("rst_hold_q8", out8_q, 8'h00);
    end

    // Release between edges: nothing changes until the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_before_q1", {7'd0, out1_q}, 8'h00);
    @(posedge clk);
    #1;
    chk("rel_after_q1", {7'd0, out1_q}, 8'h01);
    chk("rel_after_q8", out8_q, 8'h22);

    // Asynchronous reset mid-cycle clears out_q without an edge; out unaffected
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q1", {7'd0, out1_q}, 8'h00);
    chk("async_q8", out8_q, 8'h00);
    chk("async_out1", {7'd0, out1}, 8'h01);
    chk("async_out8", out8, 8'h22);
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot bytes: out follows now, out_q one cycle later
    d8[0] = 8'h11; d8[1] = 8'h22; d8[2] = 8'h44; d8[3] = 8'h88;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel = 2'(s);
      #1;
      chk("w8_out", out8, 8'h11 << s);
      @(posedge clk);
      #1;
      chk("w8_q", out8_q, 8'h11 << s);
    end

    // Random cycles with occasional reset pulses; model out_q against the sampled selection
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        d8[k] = 8'($urandom);
        d1[k] = 1'($urandom);
      end
      sel   = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 15) != 0);
      #1;
      chk("rnd_out8", out8, ref8(sel));
      chk("rnd_out1", {7'd0, out1}, {7'd0, ref1(sel)});
      if (!rst_n) chk("rnd_rst_q8", out8_q, 8'h00);
      exp_q8 = rst_n ? ref8(sel) : 8'h00;
      exp_q1 = rst_n ? ref1(sel) : 1'b0;
      @(posedge clk);
      #1;
      chk("rnd_q8", out8_q, exp_q8);
      chk("rnd_q1", {7'd0, out1_q}, {7'd0, exp_q1});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
